// File: rtl/and_tb_pkg.sv
// Shared types and helpers for the AND-gate checker: FSM encoding, bin count
// and the {a,b} -> bin index mapping.
package and_tb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} chk_state_e;

    localparam int NUM_BINS = 4;

    function automatic logic [1:0] bin_idx(input logic a, input logic b);
        return {a, b};
    endfunction

endpackage

// File: rtl/and_cov_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + ONE;
    end

endmodule

// File: rtl/and_cov_checker.sv
// Self-checking and coverage sink for a 2-input AND gate: per-combination hit
// counters, mismatch counting with first-failure capture, sticky coverage flag.
module and_cov_checker
    import and_tb_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int HIT_GOAL = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_en,
    input  logic                      clear,
    input  logic                      a,
    input  logic                      b,
    input  logic                      y,
    output logic [NUM_BINS*CNT_W-1:0] bin_cnt,
    output logic [NUM_BINS-1:0]       bin_hit,
    output logic [CNT_W-1:0]          err_cnt,
    output logic                      err_flag,
    output logic [2:0]                err_vec,
    output logic                      cov_done,
    output logic [1:0]                state
);

    if (HIT_GOAL < 1 || longint'(HIT_GOAL) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_goal
        $error("and_cov_checker: HIT_GOAL=%0d out of range 1..2**CNT_W-1", HIT_GOAL);
    end

    localparam logic [CNT_W-1:0] GOAL_M1 = CNT_W'(HIT_GOAL - 1);

    chk_state_e          state_q, state_nxt;
    logic [NUM_BINS-1:0] bin_inc, hit_nxt;
    logic                mismatch;

    assign mismatch = sample_en && (y != (a & b));

    for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
        assign bin_inc[i] = sample_en && (bin_idx(a, b) == 2'(i));

        sat_counter #(.CNT_W(CNT_W)) u_bin (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (bin_inc[i]),
            .clr   (clear),
            .cnt   (bin_cnt[i*CNT_W +: CNT_W])
        );

        // Reaching the goal this edge is exactly "one below goal and incrementing";
        // saturation cannot skip it because the goal never exceeds the counter max.
        assign hit_nxt[i] = !clear &&
                            (bin_hit[i] || (bin_inc[i] && (bin_cnt[i*CNT_W +: CNT_W] == GOAL_M1)));
    end

    sat_counter #(.CNT_W(CNT_W)) u_err (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mismatch),
        .clr   (clear),
        .cnt   (err_cnt)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:    if (sample_en) state_nxt = S_COLLECT;
            S_COLLECT: if (&hit_nxt)  state_nxt = S_DONE;
            S_DONE:    state_nxt = S_DONE;
            default:   state_nxt = S_IDLE;
        endcase
        if (clear)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bin_hit  <= '0;
            cov_done <= 1'b0;
            err_flag <= 1'b0;
            err_vec  <= '0;
        end else begin
            state_q  <= state_nxt;
            bin_hit  <= hit_nxt;
            cov_done <= (state_nxt == S_DONE);
            if (clear) begin
                err_flag <= 1'b0;
                err_vec  <= '0;
            end else if (mismatch) begin
                err_flag <= 1'b1;
                if (!err_flag)
                    err_vec <= {a, b, y};
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_and_cov_checker.sv
// Bench for and_cov_checker: three parameterisations share one directed
// stimulus stream and are checked every cycle against a behavioural model.
module tb_and_cov_checker;

    logic clk = 1'b0;
    logic rst_n, sample_en, clear, a, b, y;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance 0: CNT_W=16 HIT_GOAL=1; 1: CNT_W=16 HIT_GOAL=3; 2: CNT_W=4 HIT_GOAL=1
    logic [63:0] bc0, bc1;
    logic [15:0] bc2;
    logic [3:0]  bh[3];
    logic [15:0] ec0, ec1;
    logic [3:0]  ec2;
    logic        ef[3];
    logic [2:0]  ev[3];
    logic        cd[3];
    logic [1:0]  st[3];

    and_cov_checker #(.CNT_W(16), .HIT_GOAL(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .clear(clear), .a(a), .b(b), .y(y),
        .bin_cnt(bc0), .bin_hit(bh[0]), .err_cnt(ec0), .err_flag(ef[0]), .err_vec(ev[0]),
        .cov_done(cd[0]), .state(st[0]));

    and_cov_checker #(.CNT_W(16), .HIT_GOAL(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .clear(clear), .a(a), .b(b), .y(y),
        .bin_cnt(bc1), .bin_hit(bh[1]), .err_cnt(ec1), .err_flag(ef[1]), .err_vec(ev[1]),
        .cov_done(cd[1]), .state(st[1]));

    and_cov_checker #(.CNT_W(4), .HIT_GOAL(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .clear(clear), .a(a), .b(b), .y(y),
        .bin_cnt(bc2), .bin_hit(bh[2]), .err_cnt(ec2), .err_flag(ef[2]), .err_vec(ev[2]),
        .cov_done(cd[2]), .state(st[2]));

    logic [63:0] act_bc[3];
    logic [63:0] act_ec[3];
    assign act_bc[0] = bc0;
    assign act_bc[1] = bc1;
    assign act_bc[2] = 64'(bc2);
    assign act_ec[0] = 64'(ec0);
    assign act_ec[1] = 64'(ec1);
    assign act_ec[2] = 64'(ec2);

    // ---------------- behavioural model ----------------
    int  cw[3]   = '{16, 16, 4};
    int  goal[3] = '{1, 3, 1};
    int  m_cnt[3][4];
    int  m_err[3];
    bit  m_flag[3];
    logic [2:0] m_vec[3];
    bit  m_active;

    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int ix;
        bit mm;
        if (!rst_n || clear) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 4; i++) m_cnt[k][i] <= 0;
                m_err[k]  <= 0;
                m_flag[k] <= 1'b0;
                m_vec[k]  <= 3'b000;
            end
            m_active <= 1'b0;
        end else if (sample_en) begin
            ix = 2 * int'(a) + int'(b);
            mm = (y !== (a & b));
            m_active <= 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (m_cnt[k][ix] < sat_max(cw[k])) m_cnt[k][ix] <= m_cnt[k][ix] + 1;
                if (mm) begin
                    if (m_err[k] < sat_max(cw[k])) m_err[k] <= m_err[k] + 1;
                    if (!m_flag[k]) m_vec[k] <= {a, b, y};
                    m_flag[k] <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        logic [63:0] e_bc;
        logic [3:0]  e_bh;
        logic        e_cov;
        logic [1:0]  e_st;
        for (int k = 0; k < 3; k++) begin
            e_bc = '0;
            e_bh = '0;
            for (int i = 0; i < 4; i++) begin
                e_bc = e_bc | (64'(m_cnt[k][i]) << (i * cw[k]));
                e_bh[i] = (m_cnt[k][i] >= goal[k]);
            end
            e_cov = &e_bh;
            e_st  = e_cov ? 2'd2 : (m_active ? 2'd1 : 2'd0);
            chk($sformatf("cyc%0d.bin_cnt", k),  act_bc[k],     e_bc);
            chk($sformatf("cyc%0d.bin_hit", k),  64'(bh[k]),    64'(e_bh));
            chk($sformatf("cyc%0d.err_cnt", k),  act_ec[k],     64'(m_err[k]));
            chk($sformatf("cyc%0d.err_flag", k), 64'(ef[k]),    64'(m_flag[k]));
            chk($sformatf("cyc%0d.err_vec", k),  64'(ev[k]),    64'(m_vec[k]));
            chk($sformatf("cyc%0d.cov_done", k), 64'(cd[k]),    64'(e_cov));
            chk($sformatf("cyc%0d.state", k),    64'(st[k]),    64'(e_st));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic en, input logic clr, input logic ia, input logic ib, input logic iy);
        sample_en = en;
        clear     = clr;
        a         = ia;
        b         = ib;
        y         = iy;
        @(posedge clk);
        #2;
        sample_en = 1'b0;
        clear     = 1'b0;
        a         = 1'bx;
        b         = 1'bx;
        y         = 1'bx;
    endtask

    task automatic good(input logic ia, input logic ib, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, ia, ib, ia & ib);
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b0; clear = 1'b0; a = 1'b0; b = 1'b0; y = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst.bin_cnt", bc0, 64'h0);
        chk("rst.state", 64'(st[0]), 64'd0);
        chk("rst.cov_done", 64'(cd[0]), 64'd0);

        // One hit per bin, goal 1: coverage completes on the fourth sample.
        good(1'b0, 1'b0, 1); good(1'b0, 1'b1, 1); good(1'b1, 1'b0, 1);
        chk("t1.cov_before", 64'(cd[0]), 64'd0);
        good(1'b1, 1'b1, 1);
        chk("t1.bin_cnt", bc0, 64'h0001_0001_0001_0001);
        chk("t1.bin_hit", 64'(bh[0]), 64'hF);
        chk("t1.cov_done", 64'(cd[0]), 64'd1);
        chk("t1.state", 64'(st[0]), 64'd2);
        chk("t1.err_cnt", 64'(ec0), 64'd0);
        chk("t1.g3_hit", 64'(bh[1]), 64'h0);

        // Two mismatches; the first one is the one retained.
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t2.err_cnt", 64'(ec0), 64'd2);
        chk("t2.err_flag", 64'(ef[0]), 64'd1);
        chk("t2.err_vec", 64'(ev[0]), 64'b110);

        // Clear and sample together: clear wins, sample dropped.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5.bin_cnt", bc0, 64'h0);
        chk("t5.err_cnt", 64'(ec0), 64'd0);
        chk("t5.err_vec", 64'(ev[0]), 64'd0);
        chk("t5.state", 64'(st[0]), 64'd0);

        // Goal 3: bin 11 one short keeps coverage open.
        good(1'b0, 1'b0, 3); good(1'b0, 1'b1, 3); good(1'b1, 1'b0, 3); good(1'b1, 1'b1, 2);
        chk("t3.bin_hit", 64'(bh[1]), 64'b0111);
        chk("t3.cov_done", 64'(cd[1]), 64'd0);
        chk("t3.state", 64'(st[1]), 64'd1);
        good(1'b1, 1'b1, 1);
        chk("t3.cov_final", 64'(cd[1]), 64'd1);
        chk("t3.state_final", 64'(st[1]), 64'd2);

        // 4-bit counters saturate at 15 without disturbing other bins.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        good(1'b1, 1'b1, 20);
        chk("t4.w4_bin_cnt", 64'(bc2), 64'hF000);
        chk("t4.w16_bin_cnt", bc0, 64'h0014_0000_0000_0000);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4.w4_err_sat", 64'(ec2), 64'd15);
        chk("t4.w16_err", 64'(ec0), 64'd17);
        chk("t4.w4_err_vec", 64'(ev[2]), 64'b001);

        // Reach DONE with errors recorded, then reset asynchronously mid-cycle.
        good(1'b0, 1'b1, 1); good(1'b1, 1'b0, 1);
        chk("t6.pre_cov", 64'(cd[0]), 64'd1);
        chk("t6.pre_flag", 64'(ef[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6.bin_cnt", bc0, 64'h0);
        chk("t6.bin_hit", 64'(bh[0]), 64'h0);
        chk("t6.err_cnt", 64'(ec0), 64'd0);
        chk("t6.err_flag", 64'(ef[0]), 64'd0);
        chk("t6.err_vec", 64'(ev[0]), 64'd0);
        chk("t6.cov_done", 64'(cd[0]), 64'd0);
        chk("t6.state", 64'(st[0]), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_cov_checker.md
Name: and_cov_checker

Overview:
- Downstream stage of the 2-input AND gate; watches the gate's inputs a, b and output y on every qualified cycle.
- Checks y against a & b and keeps one saturating hit counter per input combination (00/01/10/11).
- Counts mismatches and captures the first failing vector.
- Raises a sticky coverage-complete flag once every combination reaches the hit goal. Used as the self-checking and coverage sink in gate-level experiments.

Parameters:
CNT_W, 16, width of each hit counter and of the error counter
HIT_GOAL, 1, minimum hits per bin before that bin counts as covered (1..2**CNT_W-1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
sample_en  input  1  qualifies a/b/y this cycle
clear  input  1  synchronous clear of all counters, flags and capture
a  input  1  gate input a (same signal that drives the gate)
b  input  1  gate input b
y  input  1  gate output under check
bin_cnt  output  4*CNT_W  packed hit counters; slice [i*CNT_W +: CNT_W] is combination i = {a,b}
bin_hit  output  4  bit i set once bin i has reached HIT_GOAL
err_cnt  output  CNT_W  number of mismatching samples, saturating
err_flag  output  1  sticky: at least one mismatch since reset/clear
err_vec  output  3  {a,b,y} of the first mismatch; 0 until one occurs
cov_done  output  1  sticky: all four bins covered
state  output  2  FSM state (debug): 0 IDLE, 1 COLLECT, 2 DONE

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and counters go to 0; state goes to IDLE. Release is synchronous to clk in the integrating design.
- All outputs are registered. A sample taken at edge N is visible after edge N; one-cycle latency.
- Sample (sample_en=1, clear=0):
  - idx = {a,b}.
  - bin_cnt[idx] increments, saturating at 2**CNT_W-1.
  - If y != (a & b): err_cnt increments (saturating) and err_flag is set.
  - If err_flag was 0 before this edge, err_vec captures {a,b,y}. Later mismatches never overwrite err_vec.
- bin_hit[i] is set at the edge where bin_cnt[i] first reaches HIT_GOAL. It is sticky and is derived from the next-state counter value, so it sets in the same cycle as the counter reaches the goal.
- FSM:
  - IDLE -> COLLECT on the first sample.
  - COLLECT -> DONE at the edge where the next-state bin_hit equals 4'b1111. cov_done rises at that same edge.
  - DONE persists. Counting and error checking continue in DONE.
  - Any state -> IDLE on clear.
- clear has priority over sample_en in the same cycle. The sample is dropped, and all counters, flags, err_vec and bin_hit return to 0.
- Saturation: a counter at its maximum stays at its maximum. Saturation of any counter never affects the other counters or the flags.
- sample_en=0: all state holds. a, b and y are ignored and may be X.
- A mismatch never blocks coverage. cov_done and err_flag are independent.
- Reset asserted mid-operation: everything returns to its reset value immediately, without waiting for a clock edge.
- HIT_GOAL=0 is illegal. Flag it with an elaboration-time assertion.

Decomposition:
- Shared package and_tb_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} chk_state_e;
  - localparam NUM_BINS = 4;
  - the function bin_idx(a,b) returning {a,b}.
- One natural sub-module: sat_counter (CNT_W-wide, inputs inc and clr, saturating). It is instantiated 5 times: 4 bins plus the error counter.

Test Plan:
1. Reset, then drive one sample of each of 00, 01, 10, 11 with the correct y on consecutive cycles (HIT_GOAL=1) -> each bin_cnt slice is 1, bin_hit=4'b1111, cov_done rises the cycle after the 4th sample, state=2, err_cnt=0.
2. Sample a=1, b=1, y=0, then a=0, b=1, y=1 -> err_cnt=2, err_flag=1, err_vec=3'b110 (first error retained).
3. HIT_GOAL=3, with 3 samples each of 00, 01, 10 and 2 samples of 11 -> bin_hit=4'b0111, cov_done=0, state=1. One more 11 -> cov_done=1.
4. CNT_W=4, with 20 correct samples of 11 -> the 11 slice saturates at 15 and the other slices stay 0.
5. clear and sample_en high in the same cycle after some activity -> all counters 0, err_vec=0, state=0, and the sample is not counted.
6. Assert rst_n low between clock edges while in DONE with err_flag=1 -> all outputs are 0 immediately, before the next clk edge.
